// File: rtl/button_conditioner.sv
// Button input stage: 2-FF sync, polarity normalise, debounce, edge pulses.
// Ports: CLK, RST_N (async low), i_Buttons raw pins; o_Level/o_Press/o_Release active-high.
// Macro AUTOREPEAT_EN adds held-button repeat presses on REPEAT_MASK bits.
module button_conditioner #(
  parameter int                   N_BUTTONS       = 4,
  parameter int                   DEBOUNCE_LIMIT  = 250000,
  parameter logic [N_BUTTONS-1:0] ACTIVE_LOW_MASK = 4'b1110,
  parameter int                   REPEAT_DELAY    = 12500000,
  parameter int                   REPEAT_PERIOD   = 2500000,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = 4'b0010
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N_BUTTONS-1:0] i_Buttons,
  output logic [N_BUTTONS-1:0] o_Level,
  output logic [N_BUTTONS-1:0] o_Press,
  output logic [N_BUTTONS-1:0] o_Release
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);

  logic [N_BUTTONS-1:0] sync1;
  logic [N_BUTTONS-1:0] sync2;
  logic [N_BUTTONS-1:0] norm;
  logic [N_BUTTONS-1:0] accept;
  logic [N_BUTTONS-1:0] rep_fire;
  logic [CW-1:0]        cnt [N_BUTTONS];

  assign norm = sync2 ^ ACTIVE_LOW_MASK;

  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      accept[i] = (norm[i] != o_Level[i]) &&
                  (cnt[i] == CW'(DEBOUNCE_LIMIT - 1));
    end
  end

  // Synchronisers reset to the released pin level so that
  // nothing looks pressed right after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1     <= ACTIVE_LOW_MASK;
      sync2     <= ACTIVE_LOW_MASK;
      o_Level   <= '0;
      o_Press   <= '0;
      o_Release <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1     <= i_Buttons;
      sync2     <= sync1;
      o_Level   <= o_Level ^ accept;
      o_Press   <= (accept & norm) | rep_fire;
      o_Release <= accept & ~norm;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (norm[i] == o_Level[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(RMAX + 1);

  logic [HW-1:0]        hold [N_BUTTONS];
  logic [N_BUTTONS-1:0] rep_phase;

  // rep_phase selects first-delay vs steady period; a release
  // accepted this cycle suppresses the repeat.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      rep_fire[i] = REPEAT_MASK[i] && o_Level[i] && !accept[i] &&
                    (hold[i] == (rep_phase[i] ?
                                 HW'(REPEAT_PERIOD - 1) :
                                 HW'(REPEAT_DELAY - 1)));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rep_phase <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (!REPEAT_MASK[i] || !o_Level[i] || accept[i]) begin
          hold[i]      <= '0;
          rep_phase[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          hold[i]      <= '0;
          rep_phase[i] <= 1'b1;
        end else begin
          hold[i] <= hold[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: window-based reference model plus
// directed literal checks on latency, glitch rejection and reset.
module tb_button_conditioner;

  localparam int         LIM = 5;
  localparam int         RD  = 20;
  localparam int         RP  = 8;
  localparam logic [3:0] ALM = 4'b1110;
  localparam logic [3:0] RM  = 4'b0010;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] i_Buttons = 4'b1110;
  logic [3:0] o_Level;
  logic [3:0] o_Press;
  logic [3:0] o_Release;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int npulse = 0;

  always #5 CLK = ~CLK;

  button_conditioner #(
    .N_BUTTONS(4),
    .DEBOUNCE_LIMIT(LIM),
    .ACTIVE_LOW_MASK(ALM),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK(RM)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .i_Buttons(i_Buttons),
    .o_Level(o_Level),
    .o_Press(o_Press),
    .o_Release(o_Release)
  );

  always @(posedge CLK) cyc++;

  // Model: a level flips once the pressed-normalised pin samples
  // seen two to six edges ago all disagree with it.
  logic [3:0] hist [7];
  logic [3:0] m_lvl;
  logic [3:0] m_press;
  logic [3:0] m_rel;
  int         age [4];

  always @(posedge CLK or negedge RST_N) begin : model
    logic stable;
    if (!RST_N) begin
      for (int k = 0; k < 7; k++) hist[k] = 4'b0;
      m_lvl = 4'b0;
      m_press = 4'b0;
      m_rel = 4'b0;
      for (int b = 0; b < 4; b++) age[b] = 0;
    end else begin
      for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = i_Buttons ^ ALM;
      m_press = 4'b0;
      m_rel = 4'b0;
      for (int b = 0; b < 4; b++) begin
        stable = 1'b1;
        for (int k = 2; k < 7; k++)
          if (hist[k][b] == m_lvl[b]) stable = 1'b0;
        if (stable) begin
          m_lvl[b] = ~m_lvl[b];
          m_press[b] = m_lvl[b];
          m_rel[b] = ~m_lvl[b];
          age[b] = 0;
        end else if (m_lvl[b]) begin
          age[b]++;
`ifdef AUTOREPEAT_EN
          if (RM[b] && (age[b] == RD ||
              (age[b] > RD && (age[b] - RD) % RP == 0)))
            m_press[b] = 1'b1;
`endif
        end else begin
          age[b] = 0;
        end
      end
    end
  end

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", n, $time, a, e);
    end
  endtask

  always @(negedge CLK) begin
    chk("model_level", int'(o_Level), int'(m_lvl));
    chk("model_press", int'(o_Press), int'(m_press));
    chk("model_release", int'(o_Release), int'(m_rel));
    if (|o_Press || |o_Release) npulse++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Wait for a pulse on bit b (rel=0 press, rel=1 release).
  task automatic wait_pulse(input int b, input bit rel,
                            input string n, output int t);
    t = -1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if ((rel ? o_Release[b] : o_Press[b]) === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout got=none want=pulse", n);
    end
  endtask

  task automatic hold_count(input int b, input int p,
                            output int cnt, output int offs [8]);
    cnt = 1;
    offs[0] = 0;
    for (int k = 1; k <= 60; k++) begin
      step(1);
      if (o_Press[b] === 1'b1) begin
        if (cnt < 8) offs[cnt] = cyc - p;
        cnt++;
      end
    end
  endtask

  initial begin
    int e;
    int t;
    int p0;
    int cnt;
    int offs [8];
    int exp_offs [8];
    int exp_n;

    // 1: reset and idle
    step(3);
    chk("reset_level", int'(o_Level), 0);
    chk("reset_press", int'(o_Press), 0);
    chk("reset_release", int'(o_Release), 0);
    RST_N = 1'b1;
    p0 = npulse;
    step(50);
    chk("idle_pulses", npulse - p0, 0);
    chk("idle_level", int'(o_Level), 0);

    // 2: SW2 press/release latency
    e = cyc;
    i_Buttons[1] = 1'b0;
    wait_pulse(1, 1'b0, "sw2_press", t);
    chk("sw2_press_lat", t - e, 7);
    chk("sw2_level", int'(o_Level), 4'b0010);
    step(1);
    chk("sw2_press_width", int'(o_Press[1]), 0);
    step(8);
    e = cyc;
    i_Buttons[1] = 1'b1;
    wait_pulse(1, 1'b1, "sw2_release", t);
    chk("sw2_release_lat", t - e, 7);
    chk("sw2_level_off", int'(o_Level), 0);

    // 3: glitch rejection on SW3
    step(5);
    p0 = npulse;
    repeat (10) begin
      i_Buttons[2] = 1'b0;
      step(3);
      i_Buttons[2] = 1'b1;
      step(3);
    end
    step(10);
    chk("glitch_pulses", npulse - p0, 0);
    chk("glitch_level", int'(o_Level[2]), 0);

    // 4: simultaneous SW1/SW4
    e = cyc;
    i_Buttons[0] = 1'b1;
    i_Buttons[3] = 1'b0;
    wait_pulse(0, 1'b0, "sim_press", t);
    chk("sim_press_lat", t - e, 7);
    chk("sim_press_both", int'(o_Press), 4'b1001);
    step(3);
    i_Buttons[0] = 1'b0;
    i_Buttons[3] = 1'b1;
    wait_pulse(0, 1'b1, "sim_release", t);
    chk("sim_release_both", int'(o_Release), 4'b1001);

    // 5: reset mid-debounce, button held through reset
    step(5);
    p0 = npulse;
    i_Buttons[1] = 1'b0;
    step(3);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_level", int'(o_Level), 0);
    step(2);
    chk("rst_mid_pulses", npulse - p0, 0);
    RST_N = 1'b1;
    e = cyc;
    wait_pulse(1, 1'b0, "rst_held_press", t);
    chk("rst_held_lat", t - e, 7);
    i_Buttons[1] = 1'b1;
    wait_pulse(1, 1'b1, "rst_held_release", t);

    // 6: long hold on SW2 (repeat bit) and SW3 (no repeat)
    step(5);
`ifdef AUTOREPEAT_EN
    exp_n = 7;
    exp_offs = '{0, 20, 28, 36, 44, 52, 60, 0};
`else
    exp_n = 1;
    exp_offs = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    i_Buttons[1] = 1'b0;
    wait_pulse(1, 1'b0, "hold_sw2_press", t);
    hold_count(1, t, cnt, offs);
    chk("hold_sw2_count", cnt, exp_n);
    for (int k = 1; k < exp_n && k < cnt; k++)
      chk("hold_sw2_offset", offs[k], exp_offs[k]);
    i_Buttons[1] = 1'b1;
    wait_pulse(1, 1'b1, "hold_sw2_release", t);
    step(5);
    i_Buttons[2] = 1'b0;
    wait_pulse(2, 1'b0, "hold_sw3_press", t);
    hold_count(2, t, cnt, offs);
    chk("hold_sw3_count", cnt, 1);
    i_Buttons[2] = 1'b1;
    wait_pulse(2, 1'b1, "hold_sw3_release", t);

    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
